matrix_mem_scheduler: RTL

//  Owns the single-port 4096x16 matrix SRAM and decides who may use it: the host
//  (SPI-side loader/readback) or the transformer compute engine. Sequences

---
 rtl/matrix_mem_scheduler_pkg.sv | 15 +
 rtl/matrix_mem_scheduler_if.sv | 33 +++
 rtl/matrix_mem_scheduler_arb.sv | 29 ++
 rtl/matrix_mem_scheduler.sv | 86 ++++++++
 4 files changed

// File: rtl/matrix_mem_scheduler_pkg.sv
// matrix_mem_pkg: shared widths, scheduler state encoding and read-owner enum.
package matrix_mem_pkg;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {
    ST_LOAD    = 2'b00,
    ST_START   = 2'b01,
    ST_COMPUTE = 2'b11,
    ST_RESULT  = 2'b10
  } state_e;
  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_ENG  = 1'b1
  } owner_e;
endpackage

// File: rtl/matrix_mem_scheduler_if.sv
// matrix_mem_scheduler_if: host, engine, SRAM and sequencing signals of the scheduler.
interface matrix_mem_scheduler_if
  import matrix_mem_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) ();
  logic          h_req, h_we, h_gnt, h_rvalid;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata, h_rdata;
  logic          e_req, e_we, e_gnt, e_rvalid;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          matrix_valid, eng_start, eng_done, result_ready, sched_err;
  logic [1:0]    sched_state;
  modport slave (
    input  h_req, h_we, h_addr, h_wdata, e_req, e_we, e_addr, e_wdata,
           mem_rdata, matrix_valid, eng_done,
    output h_gnt, h_rvalid, h_rdata, e_gnt, e_rvalid, e_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, eng_start, result_ready,
           sched_err, sched_state
  );
  modport master (
    output h_req, h_we, h_addr, h_wdata, e_req, e_we, e_addr, e_wdata,
           mem_rdata, matrix_valid, eng_done,
    input  h_gnt, h_rvalid, h_rdata, e_gnt, e_rvalid, e_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, eng_start, result_ready,
           sched_err, sched_state
  );
endinterface

// File: rtl/matrix_mem_scheduler_arb.sv
// mem_grant_arb: single-grant arbiter; engine wins in COMPUTE unless the host has starved.
module mem_grant_arb
  import matrix_mem_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic   sys_clk,
  input  logic   sys_rst_n,
  input  state_e mode_i,
  input  logic   h_req_i,
  input  logic   e_req_i,
  output logic   h_gnt_o,
  output logic   e_gnt_o
);
  localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  logic [SW-1:0] starve_q, starve_d;
  logic          comp, forced;
  always_comb begin
    comp     = mode_i == ST_COMPUTE;
    forced   = starve_q == SW'(STARVE_MAX - 1);
    h_gnt_o  = h_req_i & (~comp | ~e_req_i | forced);
    e_gnt_o  = comp & e_req_i & ~(h_req_i & forced);
    starve_d = (~comp | h_gnt_o) ? '0 : h_req_i ? starve_q + SW'(1) : starve_q;
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) starve_q <= '0;
    else            starve_q <= starve_d;
  end
endmodule

// File: rtl/matrix_mem_scheduler.sv
// matrix_mem_scheduler: load/compute/readback sequencer owning the shared matrix SRAM.
module matrix_mem_scheduler
  import matrix_mem_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int TIMEOUT    = 1000000
) (
  input logic                    sys_clk,
  input logic                    sys_rst_n,
  matrix_mem_scheduler_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  state_e            state_q, state_d;
  logic              mv_q, err_q, err_d, rd_vld_q;
  owner_e            rd_own_q;
  logic [TW-1:0]     to_q, to_d;
  logic [DATA_W-1:0] h_rdata_q, e_rdata_q, h_rdata_d, e_rdata_d;
  logic              h_gnt, e_gnt, mv_rise, mv_fall, to_hit, h_rv, e_rv;
  mem_grant_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .mode_i   (state_q),
    .h_req_i  (bus.h_req),
    .e_req_i  (bus.e_req),
    .h_gnt_o  (h_gnt),
    .e_gnt_o  (e_gnt)
  );
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= ST_LOAD;
      mv_q      <= 1'b0;
      err_q     <= 1'b0;
      to_q      <= '0;
      rd_vld_q  <= 1'b0;
      rd_own_q  <= OWN_HOST;
      h_rdata_q <= '0;
      e_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      mv_q      <= bus.matrix_valid;
      err_q     <= err_d;
      to_q      <= to_d;
      rd_vld_q  <= (h_gnt & ~bus.h_we) | (e_gnt & ~bus.e_we);
      rd_own_q  <= e_gnt ? OWN_ENG : OWN_HOST;
      h_rdata_q <= h_rdata_d;
      e_rdata_q <= e_rdata_d;
    end
  end
  always_comb begin
    mv_rise = bus.matrix_valid & ~mv_q;
    mv_fall = ~bus.matrix_valid & mv_q;
    to_hit  = (state_q == ST_COMPUTE) && (to_q == TO_LAST);
    state_d = state_q;
    case (state_q)
      ST_LOAD:    if (mv_rise) state_d = ST_START;
      ST_START:   state_d = ST_COMPUTE;
      ST_COMPUTE: if (bus.eng_done || to_hit) state_d = ST_RESULT;
      default:    if (mv_fall) state_d = ST_LOAD;
    endcase
    to_d  = (state_q == ST_COMPUTE) ? to_q + TW'(1) : '0;
    // a simultaneous eng_done counts as a clean finish
    err_d = (to_hit && !bus.eng_done) ? 1'b1 :
            (state_q == ST_RESULT && state_d == ST_LOAD) ? 1'b0 : err_q;
  end
  always_comb begin
    h_rv             = rd_vld_q && rd_own_q == OWN_HOST;
    e_rv             = rd_vld_q && rd_own_q == OWN_ENG;
    h_rdata_d        = h_rv ? bus.mem_rdata : h_rdata_q;
    e_rdata_d        = e_rv ? bus.mem_rdata : e_rdata_q;
    bus.h_gnt        = h_gnt;
    bus.e_gnt        = e_gnt;
    bus.h_rvalid     = h_rv;
    bus.e_rvalid     = e_rv;
    bus.h_rdata      = h_rdata_d;
    bus.e_rdata      = e_rdata_d;
    bus.mem_en       = h_gnt | e_gnt;
    bus.mem_we       = e_gnt ? bus.e_we : h_gnt ? bus.h_we : 1'b0;
    bus.mem_addr     = e_gnt ? bus.e_addr : h_gnt ? bus.h_addr : '0;
    bus.mem_wdata    = e_gnt ? bus.e_wdata : h_gnt ? bus.h_wdata : '0;
    bus.eng_start    = state_q == ST_START;
    bus.result_ready = state_q == ST_RESULT;
    bus.sched_err    = err_q;
    bus.sched_state  = state_q;
  end
endmodule
